// File: rtl/serial_add_unit.sv
// Bit-serial W-bit adder: latches a/b on start, shifts LSB-first through a registered full adder; done pulses W cycles after accept.
// No backpressure: start is ignored while busy; optional subtract mode via SERIAL_SUB_EN (adds the sub port).
module serial_add_unit #(
    parameter  int W  = 8,
    localparam int CW = (W > 1) ? $clog2(W) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef SERIAL_SUB_EN
    input  logic         sub,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         overflow
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  opa, opb;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          accept;
    logic          last;

    // Full-adder cell built from two half adders.
    logic ha1_s, ha1_c, ha2_s, ha2_c, carry_nxt;
    assign ha1_s     = opa[0] ^ opb[0];
    assign ha1_c     = opa[0] & opb[0];
    assign ha2_s     = ha1_s ^ carry;
    assign ha2_c     = ha1_s & carry;
    assign carry_nxt = ha1_c | ha2_c;

    assign last = (cnt == CW'(W - 1));

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            opa       <= '0;
            opb       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                opa <= a;
                cnt <= '0;
`ifdef SERIAL_SUB_EN
                opb   <= sub ? ~b : b;
                carry <= sub;
`else
                opb   <= b;
                carry <= 1'b0;
`endif
            end else if (state == SHIFT) begin
                opa    <= opa >> 1;
                opb    <= opb >> 1;
                carry  <= carry_nxt;
                result <= {ha2_s, result[W-1:1]};
                cnt    <= cnt + CW'(1);
                // On the MSB step, carry still holds the carry into the MSB.
                if (last) begin
                    carry_out <= carry_nxt;
                    overflow  <= carry ^ carry_nxt;
                end
            end
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed-vector bench for serial_add_unit (W=8); subtract vectors apply when SERIAL_SUB_EN is defined.
module tb_serial_add_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         sub;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] result;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    serial_add_unit #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
`ifdef SERIAL_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
        a     = va;
        b     = vb;
        sub   = vs;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = 'x;
        b     = 'x;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic [W-1:0] exp_res,
                             input logic exp_co, input logic exp_ov);
        int n;
        int bcnt;
        n    = 0;
        bcnt = 0;
        while (!done && n < 40) begin
            if (busy) bcnt++;
            step();
            n++;
        end
        chk({tag, ".lat"},    n,         exp_lat);
        chk({tag, ".busy"},   bcnt,      exp_lat);
        chk({tag, ".res"},    result,    exp_res);
        chk({tag, ".co"},     carry_out, exp_co);
        chk({tag, ".ov"},     overflow,  exp_ov);
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sub   = 1'b0;
        step();
        step();
        chk("rst.busy", busy,      0);
        chk("rst.done", done,      0);
        chk("rst.res",  result,    0);
        chk("rst.co",   carry_out, 0);
        chk("rst.ov",   overflow,  0);
        rst_n = 1'b1;
        step();

        // 0x5A + 0x33 = 0x8D, signed overflow
        launch(8'h5A, 8'h33, 1'b0);
        chk("t1.busy0", busy, 1);
        wait_done("t1", 8, 8'h8D, 1'b0, 1'b1);
        step();
        chk("t1.doneoff", done, 0);
        chk("t1.idle",    busy, 0);

        // 0xFF + 0x01 wraps to 0 with carry
        launch(8'hFF, 8'h01, 1'b0);
        wait_done("t2", 8, 8'h00, 1'b1, 1'b0);
        step();
        chk("t2.doneoff", done, 0);

        // start held during SHIFT with new operands is ignored
        launch(8'h12, 8'h34, 1'b0);
        start = 1'b1;
        a     = 8'h99;
        b     = 8'h77;
        repeat (5) step();
        start = 1'b0;
        wait_done("t3", 3, 8'h46, 1'b0, 1'b0);
        dcnt = 0;
        repeat (12) begin
            step();
            if (done) dcnt++;
        end
        chk("t3.onedone", dcnt, 0);

        // Reset on the 4th SHIFT edge aborts
        launch(8'h0F, 8'h0F, 1'b0);
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t4.busy", busy,   0);
        chk("t4.done", done,   0);
        chk("t4.res",  result, 0);
        dcnt = 0;
        repeat (12) begin
            step();
            if (done) dcnt++;
        end
        chk("t4.nodone", dcnt, 0);
        launch(8'h22, 8'h11, 1'b0);
        wait_done("t4f", 8, 8'h33, 1'b0, 1'b0);

        // Back-to-back start in the DONE cycle
        launch(8'h01, 8'h02, 1'b0);
        chk("t5.doneoff", done, 0);
        chk("t5.busy",    busy, 1);
        wait_done("t5", 8, 8'h03, 1'b0, 0);
        step();

        // Negative + negative: 0x80 + 0x80 overflows to 0
        launch(8'h80, 8'h80, 1'b0);
        wait_done("t6", 8, 8'h00, 1'b1, 1'b1);
        step();

`ifdef SERIAL_SUB_EN
        launch(8'h10, 8'h01, 1'b1);
        wait_done("s1", 8, 8'h0F, 1'b1, 1'b0);
        step();
        launch(8'h80, 8'h01, 1'b1);
        wait_done("s2", 8, 8'h7F, 1'b1, 1'b1);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
